// File: rtl/fetch_pc_unit.sv
// IF stage and IF/ID pipeline register: owns the PC and squashes the wrong-path fetch on a redirect.
// It also generates the bolha bubble flag that ID uses to ignore the instruction in IF/ID.
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
  parameter int          CNT_W     = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             Branch,
  input  logic [31:0]      branch_target,
  input  logic             jump,
  input  logic [31:0]      jump_target,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      imem_addr,
  output logic [31:0]      if_id_instr,
  output logic [31:0]      if_id_pc,
  output logic [31:0]      if_id_pc4,
  output logic             bolha,
  output logic             misalign_err,
  output logic [CNT_W-1:0] redirect_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic {RUN, SQUASH} state_e;

  state_e           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      instr_q, instr_d;
  logic [31:0]      ifpc_q, ifpc_d;
  logic [31:0]      ifpc4_q, ifpc4_d;
  logic             mis_q, mis_d;
  logic [CNT_W-1:0] rcnt_q, rcnt_d;
  logic [CNT_W-1:0] scnt_q, scnt_d;

  logic        redirect;
  logic [31:0] target;
  logic [31:0] pc_plus4;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // A redirect is only honoured while IF/ID holds a real instruction; a bubble cannot branch.
  assign redirect = (jump | Branch) & (state_q == RUN);
  assign target   = jump ? jump_target : branch_target;
  assign pc_plus4 = pc_q + 32'd4;

  always_ff @(posedge clk) begin
    if (reset) state_q <= SQUASH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (redirect) state_d = SQUASH;
      SQUASH:  if (!stall)   state_d = RUN;
      default: state_d = SQUASH;
    endcase
  end

  always_comb begin
    bolha = (state_q == SQUASH);
  end

  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    ifpc_d  = ifpc_q;
    ifpc4_d = ifpc4_q;
    mis_d   = 1'b0;
    rcnt_d  = rcnt_q;
    scnt_d  = scnt_q;
    if (redirect) begin
      pc_d    = {target[31:2], 2'b00};
      instr_d = NOP_INSTR;
      ifpc_d  = 32'd0;
      ifpc4_d = 32'd4;
      mis_d   = (target[1:0] != 2'b00);
      rcnt_d  = sat_inc(rcnt_q);
    end else if (stall) begin
      scnt_d  = sat_inc(scnt_q);
    end else begin
      pc_d    = pc_plus4;
      instr_d = imem_rdata;
      ifpc_d  = pc_q;
      ifpc4_d = pc_plus4;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      ifpc_q  <= 32'd0;
      ifpc4_q <= 32'd4;
      mis_q   <= 1'b0;
      rcnt_q  <= '0;
      scnt_q  <= '0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      ifpc_q  <= ifpc_d;
      ifpc4_q <= ifpc4_d;
      mis_q   <= mis_d;
      rcnt_q  <= rcnt_d;
      scnt_q  <= scnt_d;
    end
  end

  assign imem_addr    = pc_q;
  assign if_id_instr  = instr_q;
  assign if_id_pc     = ifpc_q;
  assign if_id_pc4    = ifpc4_q;
  assign misalign_err = mis_q;
  assign redirect_cnt = rcnt_q;
  assign stall_cnt    = scnt_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit: each step queues the hand-computed post-edge state,
// and a monitor on the falling edge pops and compares it against the outputs.
module tb_fetch_pc_unit;

  logic        clk = 1'b0;
  logic        reset, stall, Branch, jump;
  logic [31:0] branch_target, jump_target, imem_rdata;
  logic [31:0] imem_addr, if_id_instr, if_id_pc, if_id_pc4;
  logic        bolha, misalign_err;
  logic [31:0] redirect_cnt, stall_cnt;

  localparam logic [31:0] NOP = 32'h0000_0013;

  fetch_pc_unit dut (
    .clk(clk), .reset(reset), .stall(stall), .Branch(Branch),
    .branch_target(branch_target), .jump(jump), .jump_target(jump_target),
    .imem_rdata(imem_rdata), .imem_addr(imem_addr), .if_id_instr(if_id_instr),
    .if_id_pc(if_id_pc), .if_id_pc4(if_id_pc4), .bolha(bolha),
    .misalign_err(misalign_err), .redirect_cnt(redirect_cnt), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // Instruction memory stand-in: the word returned identifies the address it came from.
  function automatic logic [31:0] ins(input logic [31:0] a);
    return {a[15:0], 16'hA5A5};
  endfunction
  assign imem_rdata = ins(imem_addr);

  typedef struct {
    string       nm;
    logic [31:0] addr, instr, pc, pc4;
    logic        bol, mis;
    logic [31:0] rc, sc;
  } exp_t;

  exp_t sbq[$];
  exp_t e;
  int   total = 0;
  int   bad   = 0;

  task automatic cmp(input string nm, input string fld, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s.%s actual=%08h required=%08h", nm, fld, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      cmp(e.nm, "imem_addr", imem_addr, e.addr);
      cmp(e.nm, "if_id_instr", if_id_instr, e.instr);
      cmp(e.nm, "if_id_pc", if_id_pc, e.pc);
      cmp(e.nm, "if_id_pc4", if_id_pc4, e.pc4);
      cmp(e.nm, "bolha", {31'd0, bolha}, {31'd0, e.bol});
      cmp(e.nm, "misalign_err", {31'd0, misalign_err}, {31'd0, e.mis});
      cmp(e.nm, "redirect_cnt", redirect_cnt, e.rc);
      cmp(e.nm, "stall_cnt", stall_cnt, e.sc);
    end
  end

  // Apply inputs for one edge, then queue the state expected after that edge.
  task automatic step(input string nm, input logic rs, input logic st,
                      input logic br, input logic [31:0] bt, input logic jp, input logic [31:0] jt,
                      input logic [31:0] ea, input logic [31:0] ei, input logic [31:0] ep,
                      input logic [31:0] ep4, input logic eb, input logic em,
                      input logic [31:0] erc, input logic [31:0] esc);
    exp_t x;
    reset = rs; stall = st; Branch = br; branch_target = bt; jump = jp; jump_target = jt;
    @(posedge clk);
    #1;
    x.nm = nm; x.addr = ea; x.instr = ei; x.pc = ep; x.pc4 = ep4;
    x.bol = eb; x.mis = em; x.rc = erc; x.sc = esc;
    sbq.push_back(x);
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; Branch = 1'b0; jump = 1'b0;
    branch_target = '0; jump_target = '0;
    //     name         rs st br bt            jp jt            addr          instr                pc            pc4           b  m  rc sc
    step("reset0",      1, 0, 0, 0,            0, 0,            32'h0,        NOP,                 32'h0,        32'h4,        1, 0, 0, 0);
    step("reset1",      1, 0, 0, 0,            0, 0,            32'h0,        NOP,                 32'h0,        32'h4,        1, 0, 0, 0);
    step("adv0",        0, 0, 0, 0,            0, 0,            32'h4,        ins(32'h0),          32'h0,        32'h4,        0, 0, 0, 0);
    step("adv4",        0, 0, 0, 0,            0, 0,            32'h8,        ins(32'h4),          32'h4,        32'h8,        0, 0, 0, 0);
    step("adv8",        0, 0, 0, 0,            0, 0,            32'hC,        ins(32'h8),          32'h8,        32'hC,        0, 0, 0, 0);
    step("advC",        0, 0, 0, 0,            0, 0,            32'h10,       ins(32'hC),          32'hC,        32'h10,       0, 0, 0, 0);
    step("branch40",    0, 0, 1, 32'h40,       0, 0,            32'h40,       NOP,                 32'h0,        32'h4,        1, 0, 1, 0);
    step("b2b_ignored", 0, 0, 1, 32'h200,      0, 0,            32'h44,       ins(32'h40),         32'h40,       32'h44,       0, 0, 1, 0);
    step("adv44",       0, 0, 0, 0,            0, 0,            32'h48,       ins(32'h44),         32'h44,       32'h48,       0, 0, 1, 0);
    step("jump1C",      0, 0, 0, 0,            1, 32'h1C,       32'h1C,       NOP,                 32'h0,        32'h4,        1, 0, 2, 0);
    step("adv1C",       0, 0, 0, 0,            0, 0,            32'h20,       ins(32'h1C),         32'h1C,       32'h20,       0, 0, 2, 0);
    step("stall1",      0, 1, 0, 0,            0, 0,            32'h20,       ins(32'h1C),         32'h1C,       32'h20,       0, 0, 2, 1);
    step("stall2",      0, 1, 0, 0,            0, 0,            32'h20,       ins(32'h1C),         32'h1C,       32'h20,       0, 0, 2, 2);
    step("stall3",      0, 1, 0, 0,            0, 0,            32'h20,       ins(32'h1C),         32'h1C,       32'h20,       0, 0, 2, 3);
    step("resume20",    0, 0, 0, 0,            0, 0,            32'h24,       ins(32'h20),         32'h20,       32'h24,       0, 0, 2, 3);
    step("jmp_over_br", 0, 1, 1, 32'h40,       1, 32'h80,       32'h80,       NOP,                 32'h0,        32'h4,        1, 0, 3, 3);
    step("squash_stal", 0, 1, 0, 0,            0, 0,            32'h80,       NOP,                 32'h0,        32'h4,        1, 0, 3, 4);
    step("adv80",       0, 0, 0, 0,            0, 0,            32'h84,       ins(32'h80),         32'h80,       32'h84,       0, 0, 3, 4);
    step("misalign",    0, 0, 0, 0,            1, 32'h102,      32'h100,      NOP,                 32'h0,        32'h4,        1, 1, 4, 4);
    step("mis_clear",   0, 0, 0, 0,            0, 0,            32'h104,      ins(32'h100),        32'h100,      32'h104,      0, 0, 4, 4);
    step("jump_top",    0, 0, 0, 0,            1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, NOP,               32'h0,        32'h4,        1, 0, 5, 4);
    step("wrap",        0, 0, 0, 0,            0, 0,            32'h0,        ins(32'hFFFF_FFFC),  32'hFFFF_FFFC, 32'h0,       0, 0, 5, 4);
    step("after_wrap",  0, 0, 0, 0,            0, 0,            32'h4,        ins(32'h0),          32'h0,        32'h4,        0, 0, 5, 4);
    step("jump300",     0, 0, 0, 0,            1, 32'h300,      32'h300,      NOP,                 32'h0,        32'h4,        1, 0, 6, 4);
    step("rst_squash",  1, 0, 1, 32'h500,      0, 0,            32'h0,        NOP,                 32'h0,        32'h4,        1, 0, 0, 0);
    step("post_rst",    0, 0, 0, 0,            0, 0,            32'h4,        ins(32'h0),          32'h0,        32'h4,        0, 0, 0, 0);

    for (int i = 0; i < 20 && sbq.size() > 0; i++) @(posedge clk);
    if (sbq.size() > 0) begin
      bad++;
      total++;
      $display("FAIL drain pending=%0d required=0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
